// File: rtl/signed_add_arb_pkg.sv
// rtl/signed_add_arb_pkg.sv - shared widths and types for the signed add arbiter
package signed_add_arb_pkg;

    localparam int DATA_W    = 4;
    localparam int OVF_CNT_W = 8;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [OVF_CNT_W-1:0] ovf_cnt_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter.sv - combinational round-robin grant starting the search at ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/signed_add_with_overflow.sv
// rtl/signed_add_with_overflow.sv - two's-complement adder with signed overflow flag
module signed_add_with_overflow
    import signed_add_arb_pkg::*;
(
    input  data_t a,
    input  data_t b,
    output data_t sum,
    output logic  overflow
);

    assign sum = a + b;

    // Overflow only when both operands share a sign that the sum does not.
    assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/signed_add_arbiter.sv
// rtl/signed_add_arbiter.sv - shared signed adder arbitrated round-robin among requesters
module signed_add_arbiter
    import signed_add_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  data_t [N_REQ-1:0]      req_a,
    input  data_t [N_REQ-1:0]      req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output data_t                  res_sum,
    output logic                   res_overflow,
    output ovf_cnt_t               ovf_count
);

    out_state_t      state, state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic            free;
    logic            granted;
    data_t           add_sum;
    logic            add_ovf;

    assign res_valid = (state == ST_FULL);
    // Gating with rst_n keeps req_ready low for the whole reset assertion.
    assign free      = (!res_valid || res_ready) && rst_n;
    assign granted   = |gnt;
    assign req_ready = gnt;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .en    (free),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    signed_add_with_overflow u_add (
        .a        (req_a[gnt_idx]),
        .b        (req_b[gnt_idx]),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (granted) state_next = ST_FULL;
            ST_FULL:  if (!granted && res_ready) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            res_id       <= '0;
            res_sum      <= '0;
            res_overflow <= 1'b0;
        end else if (granted) begin
            ptr          <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            res_id       <= gnt_idx;
            res_sum      <= add_sum;
            res_overflow <= add_ovf;
        end
    end

    // Counts the result leaving this edge, independent of any new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (res_valid && res_ready && res_overflow && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_signed_add_arbiter.sv
// tb/tb_signed_add_arbiter.sv - directed self-checking bench for signed_add_arbiter
module tb_signed_add_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][3:0]  req_a;
    logic [3:0][3:0]  req_b;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_id;
    logic [3:0]       res_sum;
    logic             res_overflow;
    logic [7:0]       ovf_count;

    int errors = 0;
    int checks = 0;

    signed_add_arbiter #(.N_REQ(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_sum      (res_sum),
        .res_overflow (res_overflow),
        .ovf_count    (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        req_valid = '0;
        res_ready = 1'b1;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        tick();
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf got=%0d exp=0", ovf_count); end
        checks++; if ({res_id, res_sum, res_overflow} !== 7'd0) begin errors++; $display("FAIL reset_res got=%b exp=0", {res_id, res_sum, res_overflow}); end
        req_valid = '0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_arith();
        logic [3:0] va [4] = '{4'b0111, 4'b1000, 4'b0011, 4'b1110};
        logic [3:0] vb [4] = '{4'b0001, 4'b1111, 4'b1100, 4'b1101};
        logic [3:0] vs [4] = '{4'b1000, 4'b0111, 4'b1111, 4'b1011};
        logic       vo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int exp_ovf = 0;
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            req_a[0]  = va[k];
            req_b[0]  = vb[k];
            req_valid = 4'b0001;
            res_ready = 1'b1;
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL arith_ready[%0d] got=%b exp=0001", k, req_ready); end
            tick();
            req_valid = '0;
            if (k > 0 && vo[k-1]) exp_ovf++;
            #1;
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL arith_valid[%0d] got=%b exp=1", k, res_valid); end
            checks++; if (res_sum !== vs[k]) begin errors++; $display("FAIL arith_sum[%0d] got=%b exp=%b", k, res_sum, vs[k]); end
            checks++; if (res_overflow !== vo[k]) begin errors++; $display("FAIL arith_ovf[%0d] got=%b exp=%b", k, res_overflow, vo[k]); end
            checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL arith_id[%0d] got=%0d exp=0", k, res_id); end
            checks++; if (ovf_count !== 8'(exp_ovf)) begin errors++; $display("FAIL arith_cnt[%0d] got=%0d exp=%0d", k, ovf_count, exp_ovf); end
        end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL arith_drain got=%b exp=0", res_valid); end
        checks++; if (ovf_count !== 8'd2) begin errors++; $display("FAIL arith_final_cnt got=%0d exp=2", ovf_count); end
    endtask

    task automatic test_round_robin_and_hold();
        int exp_id [6] = '{0, 1, 2, 3, 0, 1};
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i] = 4'(i);
            req_b[i] = 4'd1;
        end
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (req_ready !== 4'(1 << exp_id[k])) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp_id=%0d", k, req_ready, exp_id[k]); end
            tick();
            checks++; if (res_valid !== 1'b1 || res_id !== 2'(exp_id[k])) begin errors++; $display("FAIL rr_id[%0d] got=%0d valid=%b exp=%0d", k, res_id, res_valid, exp_id[k]); end
            checks++; if (res_sum !== 4'(exp_id[k] + 1)) begin errors++; $display("FAIL rr_sum[%0d] got=%0d exp=%0d", k, res_sum, exp_id[k] + 1); end
        end
        res_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready[%0d] got=%b exp=0000", k, req_ready); end
            tick();
            checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== 4'd2) begin errors++; $display("FAIL hold_out[%0d] got=v%b id%0d s%0d exp=v1 id1 s2", k, res_valid, res_id, res_sum); end
        end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_release_ready got=%b exp=0100", req_ready); end
        tick();
        checks++; if (res_id !== 2'd2 || res_sum !== 4'd3) begin errors++; $display("FAIL hold_release_id got=%0d sum=%0d exp=2 sum=3", res_id, res_sum); end
        req_valid = '0;
    endtask

    task automatic test_saturation();
        pulse_reset();
        req_a[0]  = 4'b0111;
        req_b[0]  = 4'b0001;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        for (int n = 0; n < 200; n++) tick();
        checks++; if (ovf_count !== 8'd199) begin errors++; $display("FAIL sat_mid got=%0d exp=199", ovf_count); end
        for (int n = 0; n < 61; n++) tick();
        checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL sat_top got=%0d exp=255", ovf_count); end
        for (int n = 0; n < 5; n++) tick();
        checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL sat_stick got=%0d exp=255", ovf_count); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        req_a[3]  = 4'd5; req_b[3] = 4'd1;
        req_a[2]  = 4'd2; req_b[2] = 4'd2;
        req_valid = 4'b1000;
        res_ready = 1'b0;
        tick();
        req_valid = 4'b1100;
        #1;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd3) begin errors++; $display("FAIL mid_full got=v%b id%0d exp=v1 id3", res_valid, res_id); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_async_drop got=%b exp=0", res_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset got=%b exp=0000", req_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_first_grant got=%b exp=0100", req_ready); end
        tick();
        checks++; if (res_id !== 2'd2 || res_sum !== 4'd4) begin errors++; $display("FAIL mid_first_id got=%0d sum=%0d exp=2 sum=4", res_id, res_sum); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_round_robin_and_hold();
        test_saturation();
        test_reset_mid();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_add_arbiter.md
# signed_add_arbiter

Shares one 4-bit two's-complement adder with overflow detection among `N_REQ` independent requesters. Each requester offers an operand pair on a valid/ready handshake. A round-robin arbiter grants at most one pair per cycle. The registered result (sum, overflow flag, requester id) is presented on a single valid/ready output port, and a saturating counter tracks overflow events.

## Interface

- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester id; derived, do not override.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `N_REQ`: requester i has an operand pair pending.
- `req_ready`, output, `N_REQ`: one-hot or zero; requester i's pair is accepted this cycle.
- `req_a`, input, `N_REQ`×4: signed operand a per requester.
- `req_b`, input, `N_REQ`×4: signed operand b per requester.
- `res_valid`, output, 1: result register holds an undelivered result.
- `res_ready`, input, 1: consumer accepts the result this cycle.
- `res_id`, output, `ID_W`: index of the requester that produced the result.
- `res_sum`, output, 4: `a + b` modulo 16.
- `res_overflow`, output, 1: signed overflow of that addition.
- `ovf_count`, output, 8: saturating count of delivered results with `res_overflow` = 1.

## Operation

- Arithmetic:
  - `res_sum` = low 4 bits of `a + b`.
  - Overflow occurs when a[3] == b[3] and sum[3] != a[3].
  - Representable range is −8..+7. No saturation of the sum.
- Slot free: `free = !res_valid || res_ready`.
- Grant:
  - When `free` is high and any `req_valid` is set, exactly one requester is granted.
  - Only the granted requester sees `req_ready[i]` = 1.
  - If `free` is low, all `req_ready` bits are 0.
- Round-robin: the search starts at `ptr` and wraps modulo `N_REQ`. On each grant, `ptr` becomes (granted index + 1) mod `N_REQ`. `ptr` does not change without a grant.
- Combinational paths:
  - `req_ready` depends combinationally on `req_valid` and `res_ready`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Request holding: a requester holds `req_valid`, `req_a` and `req_b` stable until accepted. Dropping `req_valid` early is legal and simply withdraws the request.
- Output hold: while `res_valid` && !`res_ready`, `res_id`, `res_sum` and `res_overflow` hold stable.
- Output state machine:
  - States are EMPTY (`res_valid` = 0) and FULL (`res_valid` = 1).
  - EMPTY → FULL on a grant.
  - FULL → FULL on a grant with `res_ready`: back-to-back, the register is overwritten with the new result.
  - FULL → EMPTY on `res_ready` without a grant.
- Overflow counter: `ovf_count` increments when `res_valid` && `res_ready` && `res_overflow`. It sticks at 255.

## Timing

- Latency: a pair accepted at edge k appears on the `res_*` outputs after edge k, i.e. one cycle.
- Throughput: one result per cycle while `res_ready` = 1 and requests are pending.
- Reset values (async assert, sync release):
  - `res_valid` = 0, `res_id` = 0, `res_sum` = 0, `res_overflow` = 0.
  - `ovf_count` = 0, `ptr` = 0.
  - `req_ready` = 0 while `rst_n` = 0.
- Reset mid-operation: a held result is discarded. Pending requests are re-arbitrated from requester 0 after release.
- Simultaneous drain, grant and overflow: the delivered result's overflow updates `ovf_count` in the same edge that loads the new result.

## Structure

- Package `signed_add_arb_pkg`: `DATA_W` = 4, `OVF_CNT_W` = 8, typedef `data_t` (logic [DATA_W-1:0]), typedef `ovf_cnt_t`.
- Sub-modules:
  - `rr_arbiter` (parameter `N`): request vector, enable and pointer in; one-hot grant and encoded index out. It is purely combinational; `ptr` stays in the parent.
  - The adder is the existing `signed_add_with_overflow`, instantiated once on the muxed operands.

## Test plan

- Single requester 0, a=0111, b=0001, `res_ready` = 1 → next cycle `res_sum` = 1000, `res_overflow` = 1, `res_id` = 0, `ovf_count` → 1 after delivery.
- a=1000, b=1111 → sum 0111, overflow 1. a=0011, b=1100 → sum 1111, overflow 0. a=1110, b=1101 → sum 1011, overflow 0.
- All 4 requesters continuously valid, `res_ready` = 1 → `res_id` sequence 0,1,2,3,0,1 with no idle cycles.
- `res_ready` = 0 for 3 cycles with a result held → all `req_ready` = 0, outputs stable. On release, the next id follows round-robin order.
- 260 consecutive overflowing results delivered → `ovf_count` reaches 255 and stays.
- `rst_n` pulsed low while FULL with requesters 2 and 3 pending → `res_valid` drops immediately; the first grant after release is id 2, since `ptr` = 0.
